// File: rtl/sobol_pkg.sv
// Shared types and reset direction-vector tables for the Sobol point generator.
package sobol_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int unsigned M_TABLE_LEN = 16;

    // Dimension-1 odd multipliers m[k]; v[k] = m[k] << (WIDTH-1-k).
    localparam logic [15:0] DIM1_M [M_TABLE_LEN] = '{
        16'd1,    16'd3,    16'd5,     16'd15,
        16'd17,   16'd51,   16'd85,    16'd255,
        16'd257,  16'd771,  16'd1285,  16'd3855,
        16'd4369, 16'd13107, 16'd21845, 16'd65535
    };

    // Reset direction vector for (dim, k); dim0 and dims >= 2 use the identity vectors.
    function automatic logic [31:0] default_dv(input int unsigned dim,
                                               input int unsigned k,
                                               input int unsigned width);
        logic [31:0] m;
        if (dim == 32'd1 && k < M_TABLE_LEN) begin
            m = 32'(DIM1_M[k]);
        end else begin
            m = 32'd1;
        end
        if (k >= width) begin
            return 32'd0;
        end
        return m << (width - 32'd1 - k);
    endfunction

endpackage

// File: rtl/sobol_lsz_idx.sv
// Index of the least-significant zero bit of the counter; all-ones maps to WIDTH-1.
module sobol_lsz_idx #(
    parameter int unsigned WIDTH = 8,
    localparam int unsigned IDX_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] cnt,
    output logic [IDX_W-1:0] lsz_idx_c
);

    // Scan from the top so the lowest zero wins; no zero leaves the WIDTH-1 default.
    always_comb begin
        lsz_idx_c = IDX_W'(WIDTH - 1);
        for (int unsigned i = WIDTH; i > 0; i--) begin
            if (!cnt[i-1]) begin
                lsz_idx_c = IDX_W'(i - 1);
            end
        end
    end

endmodule

// File: rtl/sobol_rng_multidim.sv
// Multi-dimension Sobol point generator with valid/ready output and loadable direction vectors.
module sobol_rng_multidim
    import sobol_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned DIMS      = 2,
    parameter int unsigned WRAP_STOP = 0,
    localparam int unsigned DIM_W    = (DIMS > 1) ? $clog2(DIMS) : 1,
    localparam int unsigned IDX_W    = $clog2(WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  restart,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DIMS*WIDTH-1:0] out_data,
    output logic [WIDTH-1:0]      out_idx,
    output logic                  wrap,
    output logic                  done,
    input  logic                  dv_we,
    input  logic [DIM_W-1:0]      dv_dim,
    input  logic [IDX_W-1:0]      dv_idx,
    input  logic [WIDTH-1:0]      dv_data
);

    state_e                                   state_q, state_d;
    logic [WIDTH-1:0]                         cnt_q, cnt_d;
    logic [DIMS-1:0][WIDTH-1:0]               pt_q, pt_d;
    logic [DIMS-1:0][WIDTH-1:0][WIDTH-1:0]    dv_q, dv_d;
    logic                                     valid_q, valid_d;
    logic                                     wrap_q, wrap_d;
    logic                                     done_q, done_d;
    logic [IDX_W-1:0]                         lsz_c;
    logic                                     fire_c;

    sobol_lsz_idx #(.WIDTH(WIDTH)) u_lsz (
        .cnt       (cnt_q),
        .lsz_idx_c (lsz_c)
    );

    assign fire_c = valid_q & out_ready;

    // Next-state: FSM, Gray-code advance, wrap detection and direction-vector writes.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pt_d    = pt_q;
        dv_d    = dv_q;
        wrap_d  = 1'b0;

        if (restart) begin
            state_d = IDLE;
            cnt_d   = '0;
            pt_d    = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (fire_c) begin
                        cnt_d = cnt_q + 1'b1;
                        for (int unsigned d = 0; d < DIMS; d++) begin
                            pt_d[d] = pt_q[d] ^ dv_q[d][lsz_c];
                        end
                        if (&cnt_q) begin
                            wrap_d = 1'b1;
                            if (WRAP_STOP != 0) begin
                                state_d = DONE;
                            end
                        end
                    end
                end
                DONE: begin
                    state_d = DONE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        // Writes land after any same-cycle advance, which therefore sees the old vector.
        for (int unsigned d = 0; d < DIMS; d++) begin
            for (int unsigned k = 0; k < WIDTH; k++) begin
                if (dv_we && dv_dim == DIM_W'(d) && dv_idx == IDX_W'(k)) begin
                    dv_d[d][k] = dv_data;
                end
            end
        end

        valid_d = (state_d == RUN);
        done_d  = (state_d == DONE);
    end

    // State, counter, point and direction-vector registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pt_q    <= '0;
            valid_q <= 1'b0;
            wrap_q  <= 1'b0;
            done_q  <= 1'b0;
            for (int unsigned d = 0; d < DIMS; d++) begin
                for (int unsigned k = 0; k < WIDTH; k++) begin
                    dv_q[d][k] <= WIDTH'(default_dv(d, k, WIDTH));
                end
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pt_q    <= pt_d;
            valid_q <= valid_d;
            wrap_q  <= wrap_d;
            done_q  <= done_d;
            dv_q    <= dv_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = pt_q;
    assign out_idx   = cnt_q;
    assign wrap      = wrap_q;
    assign done      = done_q;

endmodule

// File: tb/tb_sobol_rng_multidim.sv
// Randomised and directed bench for the Sobol generator against a point-level reference model.
module tb_sobol_rng_multidim;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, restart, out_ready;
    logic        dv_we;
    logic        dv_dim;
    logic [2:0]  dv_idx;
    logic [7:0]  dv_data;
    logic        out_valid, wrap, done;
    logic [15:0] out_data;
    logic [7:0]  out_idx;

    logic        start1, restart1, ready1;
    logic        out_valid1, wrap1, done1;
    logic [15:0] out_data1;
    logic [7:0]  out_idx1;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state for the free-running instance.
    bit          m_run;
    bit          m_wrap;
    logic [7:0]  m_cnt;
    logic [7:0]  m_pt [2];
    logic [7:0]  m_dv [2][8];

    int unsigned dim1_m [8] = '{1, 3, 5, 15, 17, 51, 85, 255};

    always #5 clk = ~clk;

    sobol_rng_multidim #(.WIDTH(8), .DIMS(2), .WRAP_STOP(0)) dut (
        .clk(clk), .rst(rst), .start(start), .restart(restart),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_idx(out_idx), .wrap(wrap), .done(done),
        .dv_we(dv_we), .dv_dim(dv_dim), .dv_idx(dv_idx), .dv_data(dv_data)
    );

    sobol_rng_multidim #(.WIDTH(8), .DIMS(2), .WRAP_STOP(1)) dut_ws (
        .clk(clk), .rst(rst), .start(start1), .restart(restart1),
        .out_valid(out_valid1), .out_ready(ready1), .out_data(out_data1),
        .out_idx(out_idx1), .wrap(wrap1), .done(done1),
        .dv_we(1'b0), .dv_dim(1'b0), .dv_idx(3'd0), .dv_data(8'd0)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] def_dv(input int dim, input int k);
        int unsigned m;
        m = (dim == 1) ? dim1_m[k] : 1;
        return 8'(m << (7 - k));
    endfunction

    // Closed form: point i is the XOR of v[j] over the set bits of gray(i).
    function automatic logic [7:0] gray_pt(input int dim, input int i);
        int g;
        logic [7:0] x;
        g = i ^ (i >> 1);
        x = 8'd0;
        for (int j = 0; j < 8; j++) begin
            if (((g >> j) % 2) == 1) x = x ^ def_dv(dim, j);
        end
        return x;
    endfunction

    task automatic model_reset();
        m_run = 1'b0;
        m_wrap = 1'b0;
        m_cnt = 8'd0;
        for (int d = 0; d < 2; d++) begin
            m_pt[d] = 8'd0;
            for (int k = 0; k < 8; k++) m_dv[d][k] = def_dv(d, k);
        end
    endtask

    // Apply one clock edge of the specified behaviour to the model.
    task automatic model_step();
        int c;
        int k;
        if (rst) begin
            model_reset();
            return;
        end
        m_wrap = 1'b0;
        if (restart) begin
            m_run = 1'b0;
            m_cnt = 8'd0;
            m_pt[0] = 8'd0;
            m_pt[1] = 8'd0;
        end else if (!m_run) begin
            if (start) m_run = 1'b1;
        end else if (out_ready) begin
            c = int'(m_cnt);
            k = 0;
            while ((c % 2) == 1 && k < 7) begin
                c = c / 2;
                k++;
            end
            for (int d = 0; d < 2; d++) m_pt[d] = m_pt[d] ^ m_dv[d][k];
            if (m_cnt == 8'd255) m_wrap = 1'b1;
            m_cnt = 8'((int'(m_cnt) + 1) % 256);
        end
        if (dv_we) m_dv[dv_dim][dv_idx] = dv_data;
    endtask

    task automatic compare0();
        check("valid", 32'(out_valid), 32'(m_run));
        check("wrap", 32'(wrap), 32'(m_wrap));
        check("done", 32'(done), 32'd0);
        if (m_run) begin
            check("idx", 32'(out_idx), 32'(m_cnt));
            check("dim0", 32'(out_data[7:0]), 32'(m_pt[0]));
            check("dim1", 32'(out_data[15:8]), 32'(m_pt[1]));
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        compare0();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] exp0 [6] = '{8'd0, 8'd128, 8'd192, 8'd64, 8'd96, 8'd224};
        logic [7:0] exp1 [4] = '{8'd0, 8'd128, 8'd64, 8'd192};
        bit seen;

        rst = 1'b1; start = 1'b0; restart = 1'b0; out_ready = 1'b0;
        dv_we = 1'b0; dv_dim = 1'b0; dv_idx = 3'd0; dv_data = 8'd0;
        start1 = 1'b0; restart1 = 1'b0; ready1 = 1'b0;
        model_reset();
        repeat (2) cycle();
        check("rst_valid1", 32'(out_valid1), 32'd0);
        check("rst_done1", 32'(done1), 32'd0);
        check("rst_idx", 32'(out_idx), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed first points with continuous acceptance.
        start = 1'b1; out_ready = 1'b1;
        cycle();
        start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            check("seq_dim0", 32'(out_data[7:0]), 32'(exp0[i]));
            if (i < 4) check("seq_dim1", 32'(out_data[15:8]), 32'(exp1[i]));
            check("seq_idx", 32'(out_idx), 32'(i));
            cycle();
        end

        // Random back-pressure.
        for (int i = 0; i < 40; i++) begin
            out_ready = 1'($urandom % 2);
            cycle();
        end

        // Run to the period end, cross-checking the closed form with default vectors.
        out_ready = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            cycle();
            if (m_run) begin
                check("gray_dim0", 32'(out_data[7:0]), 32'(gray_pt(0, int'(m_cnt))));
                check("gray_dim1", 32'(out_data[15:8]), 32'(gray_pt(1, int'(m_cnt))));
            end
            if (wrap) seen = 1'b1;
        end
        check("wrap_seen", 32'(seen), 32'd1);
        check("wrap_idx", 32'(out_idx), 32'd0);
        check("wrap_data", 32'(out_data), 32'd0);
        check("wrap_valid", 32'(out_valid), 32'd1);

        // Direction-vector load, then a write coincident with a fire.
        restart = 1'b1;
        cycle();
        restart = 1'b0;
        dv_we = 1'b1; dv_dim = 1'b0; dv_idx = 3'd0; dv_data = 8'h55;
        cycle();
        dv_we = 1'b0;
        start = 1'b1;
        cycle();
        start = 1'b0;
        check("ld_idx0", 32'(out_idx), 32'd0);
        cycle();
        check("ld_dim0_1", 32'(out_data[7:0]), 32'h55);
        cycle();
        check("ld_dim0_2", 32'(out_data[7:0]), 32'h15);
        dv_we = 1'b1; dv_dim = 1'b0; dv_idx = 3'd0; dv_data = 8'h0F;
        cycle();
        dv_we = 1'b0;
        check("coinc_old", 32'(out_data[7:0]), 32'h40);
        cycle();
        check("coinc_k2", 32'(out_data[7:0]), 32'h60);
        cycle();
        check("coinc_new", 32'(out_data[7:0]), 32'h6F);

        // Mixed random traffic: stalls, starts, restarts and vector writes.
        for (int i = 0; i < 300; i++) begin
            out_ready = ($urandom % 4) != 0;
            start     = ($urandom % 4) == 0;
            restart   = ($urandom % 64) == 0;
            dv_we     = ($urandom % 8) == 0;
            dv_dim    = 1'($urandom % 2);
            dv_idx    = 3'($urandom % 8);
            dv_data   = 8'($urandom);
            cycle();
        end
        start = 1'b0; restart = 1'b0; dv_we = 1'b0;

        // Asynchronous reset between edges while running.
        start = 1'b1; out_ready = 1'b1;
        cycle();
        start = 1'b0;
        repeat (3) cycle();
        #2;
        rst = 1'b1;
        #1;
        check("arst_valid", 32'(out_valid), 32'd0);
        check("arst_idx", 32'(out_idx), 32'd0);
        check("arst_data", 32'(out_data), 32'd0);
        check("arst_wrap", 32'(wrap), 32'd0);
        cycle();
        @(negedge clk);
        rst = 1'b0;
        start = 1'b1;
        cycle();
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check("arst_gray0", 32'(out_data[7:0]), 32'(gray_pt(0, int'(m_cnt))));
            check("arst_gray1", 32'(out_data[15:8]), 32'(gray_pt(1, int'(m_cnt))));
            cycle();
        end

        // Stop-at-period-end instance.
        start1 = 1'b1; ready1 = 1'b1;
        cycle();
        start1 = 1'b0;
        check("ws_valid", 32'(out_valid1), 32'd1);
        check("ws_idx0", 32'(out_idx1), 32'd0);
        repeat (255) cycle();
        check("ws_idx255", 32'(out_idx1), 32'd255);
        check("ws_pre_done", 32'(done1), 32'd0);
        cycle();
        check("ws_done", 32'(done1), 32'd1);
        check("ws_valid_off", 32'(out_valid1), 32'd0);
        check("ws_wrap", 32'(wrap1), 32'd1);
        check("ws_idx_zero", 32'(out_idx1), 32'd0);
        check("ws_data_zero", 32'(out_data1), 32'd0);
        start1 = 1'b1;
        cycle();
        start1 = 1'b0;
        check("ws_start_ign", 32'(done1), 32'd1);
        check("ws_start_ign_v", 32'(out_valid1), 32'd0);
        check("ws_wrap_once", 32'(wrap1), 32'd0);
        restart1 = 1'b1;
        cycle();
        restart1 = 1'b0;
        check("ws_rs_done", 32'(done1), 32'd0);
        check("ws_rs_valid", 32'(out_valid1), 32'd0);
        start1 = 1'b1;
        cycle();
        start1 = 1'b0;
        check("ws_resume_v", 32'(out_valid1), 32'd1);
        check("ws_resume_idx", 32'(out_idx1), 32'd0);
        check("ws_resume_data", 32'(out_data1), 32'd0);
        cycle();
        check("ws_next_idx", 32'(out_idx1), 32'd1);
        check("ws_next_data", 32'(out_data1), 32'h8080);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sobol_rng_multidim.md
Name: sobol_rng_multidim

Overview:
Parametrised multi-dimension Sobol sequence generator. It produces one DIMS-wide point per accepted handshake, using the Gray-code counter plus least-significant-zero direction-vector XOR scheme. Direction vectors are runtime-loadable per dimension. It adds a start/stop state machine, valid/ready output, an optional stop-at-period-end mode and a wrap indication. It feeds unary bitstream generators (comparators) in the stochastic-computing datapath.

Parameters:
WIDTH, 8, bits per sample and counter width; legal range 2..16; period is 2^WIDTH points.
DIMS, 2, number of independent dimensions; legal range 1..8.
WRAP_STOP, 0, 1 = halt in DONE after the last point of a period; 0 = wrap and continue.

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
start  in  1  IDLE->RUN request (level-sampled)
restart  in  1  synchronous clear of counter and state; returns to IDLE
out_valid  out  1  out_data/out_idx hold a valid point
out_ready  in  1  consumer accepts the point
out_data  out  DIMS*WIDTH  point; dimension d occupies bits [d*WIDTH +: WIDTH]
out_idx  out  WIDTH  sequence index of the presented point
wrap  out  1  one-cycle pulse when the point with index 2^WIDTH-1 is accepted
done  out  1  high in DONE state (WRAP_STOP=1 only)
dv_we  in  1  direction-vector write strobe
dv_dim  in  max(1,$clog2(DIMS))  dimension to write
dv_idx  in  $clog2(WIDTH)  vector index k to write
dv_data  in  WIDTH  vector value

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values: state=IDLE, cnt=0, all dims=0, out_valid=0, out_idx=0, wrap=0, done=0.
- Reset direction vectors:
  - dim0: v[k] = 1<<(WIDTH-1-k).
  - dim1: v[k] = m[k]<<(WIDTH-1-k), with m = 1,3,5,15,17,51,85,255,257,771,1285,3855,4369,13107,21845,65535.
  - dims >=2: same as dim0 until loaded.
- State machine:
  - IDLE: out_valid=0. start=1 -> RUN next cycle.
  - RUN: out_valid=1. Advance on fire (out_valid & out_ready).
  - DONE: out_valid=0, done=1. Leaves only on restart or rst.
- Advance (one fire):
  - k = index of least-significant 0 bit of cnt; if cnt is all-ones, k=WIDTH-1.
  - Every dim d: state_d <= state_d ^ v_d[k].
  - cnt <= cnt+1, wrapping modulo 2^WIDTH.
  - Next point is presented the cycle after fire; throughput is 1 point/cycle while out_ready=1.
- out_data and out_idx are registered and stable while out_valid=1 and out_ready=0.
- Wrap: a fire with cnt==2^WIDTH-1 pulses wrap for one cycle. All states return to 0 naturally via the XOR of v[WIDTH-1].
  - WRAP_STOP=0: stay in RUN.
  - WRAP_STOP=1: go to DONE; cnt and states are already 0.
- restart: overrides fire and start in the same cycle. Next cycle: cnt=0, states=0, IDLE.
- Direction-vector writes:
  - dv_we writes v[dv_dim][dv_idx] at the clock edge. Values are visible to advances from the next cycle.
  - A fire in the same cycle uses the old value.
  - Writes are legal in any state. Out-of-range dv_dim or dv_idx is ignored.
- A start while already in RUN or DONE is ignored.

Decomposition:
- Package sobol_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - the dim1 m-table constant;
  - a function returning the default direction vector for (dim, k, WIDTH).
- Sub-module sobol_lsz_idx (WIDTH param): combinational least-significant-zero index with the all-ones -> WIDTH-1 rule. Shared by all dims.

Test Plan:
- Reset then start, out_ready=1, WIDTH=8, DIMS=2 -> dim0 points 0,128,192,64,96,224; dim1 points 0,128,64,192; out_idx 0,1,2,3.
- out_ready toggled 1,0,0,1 -> point and out_idx held during stall; no skipped or duplicated index over 16 points.
- WRAP_STOP=0, 256 fires -> wrap pulses exactly on the fire with out_idx=255; next point is index 0 with all dims 0.
- WRAP_STOP=1, 256 fires -> DONE, out_valid=0, done=1; start ignored; restart -> IDLE, then start resumes at index 0.
- Write dim0 v[0]=8'h55, then advance from cnt=0 -> dim0=8'h55. A write coincident with a fire -> that fire uses the old value.
- rst asserted mid-RUN, asynchronously between edges -> outputs clear immediately; direction vectors return to defaults.
